// File: rtl/regfile_port_sched.sv
// regfile_port_sched
//
// Owns the pins of a dual-read / single-write register file and decides, one
// cycle at a time, which requester gets them. The regfile's write address is
// its A read index, so a writeback and an operand read can never share a
// cycle. Exactly one grant is issued per cycle: ALU write, MEM write, READ,
// or nothing.
//
// Arbitration:
//   - A waiting read that has already sat through STARVE_MAX consecutive write
//     grants wins.
//   - Otherwise any valid writer wins over the read. When both writers are
//     valid they alternate, and the winner is never the last write winner.
//   - Otherwise a valid read wins.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   alu_valid/ready/index/data  ALU writeback request (ready is combinational)
//   mem_valid/ready/index/data  load writeback request (ready is combinational)
//   rd_valid/ready/a_index/b_index  operand read request (ready is combinational)
//   rsp_valid, rsp_a/b_data     registered operand response, one cycle after the grant
//   reg_write, A_index, B_index, write_data  driven to the regfile
//   A_data, B_data              read data returned by the regfile

module regfile_port_sched #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned REG_BITS   = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_BITS-1:0] alu_index,
    input  logic [WIDTH-1:0]    alu_data,

    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [REG_BITS-1:0] mem_index,
    input  logic [WIDTH-1:0]    mem_data,

    input  logic                rd_valid,
    output logic                rd_ready,
    input  logic [REG_BITS-1:0] rd_a_index,
    input  logic [REG_BITS-1:0] rd_b_index,

    output logic                rsp_valid,
    output logic [WIDTH-1:0]    rsp_a_data,
    output logic [WIDTH-1:0]    rsp_b_data,

    output logic                reg_write,
    output logic [REG_BITS-1:0] A_index,
    output logic [REG_BITS-1:0] B_index,
    output logic [WIDTH-1:0]    write_data,
    input  logic [WIDTH-1:0]    A_data,
    input  logic [WIDTH-1:0]    B_data
);

    // Counter just wide enough to hold STARVE_MAX.
    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    typedef enum logic [1:0] {
        GntNone,
        GntAlu,
        GntMem,
        GntRead
    } grant_e;

    typedef enum logic {
        SrcAlu,
        SrcMem
    } src_e;

    grant_e grant;

    src_e            rr_last_q, rr_last_d;
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_a_q, rsp_a_d;
    logic [WIDTH-1:0] rsp_b_q, rsp_b_d;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    always_comb begin
        grant = GntNone;
        if (!reset) begin
            if (rd_valid && (starve_cnt_q == CntMax)) begin
                grant = GntRead;
            end else if (alu_valid && mem_valid) begin
                // Tie: hand the port to whoever did not win last time.
                grant = (rr_last_q == SrcMem) ? GntAlu : GntMem;
            end else if (alu_valid) begin
                grant = GntAlu;
            end else if (mem_valid) begin
                grant = GntMem;
            end else if (rd_valid) begin
                grant = GntRead;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshakes and regfile pins
    // ------------------------------------------------------------------
    always_comb begin
        alu_ready  = 1'b0;
        mem_ready  = 1'b0;
        rd_ready   = 1'b0;
        reg_write  = 1'b0;
        A_index    = '0;
        write_data = '0;
        // B port is unused by writes, so it simply follows the read request.
        B_index    = rd_b_index;

        unique case (grant)
            GntAlu: begin
                alu_ready  = 1'b1;
                // r0 is hard-wired zero: ack the request but suppress the write.
                reg_write  = (alu_index != '0);
                A_index    = alu_index;
                write_data = alu_data;
            end
            GntMem: begin
                mem_ready  = 1'b1;
                reg_write  = (mem_index != '0);
                A_index    = mem_index;
                write_data = mem_data;
            end
            GntRead: begin
                rd_ready = 1'b1;
                A_index  = rd_a_index;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state: round-robin pointer, starvation counter, response
    // ------------------------------------------------------------------
    always_comb begin
        rr_last_d    = rr_last_q;
        starve_cnt_d = starve_cnt_q;
        rsp_valid_d  = 1'b0;
        rsp_a_d      = rsp_a_q;
        rsp_b_d      = rsp_b_q;

        unique case (grant)
            GntAlu:  rr_last_d = SrcAlu;
            GntMem:  rr_last_d = SrcMem;
            default: begin
            end
        endcase

        // Counts write grants the read has been made to wait through.
        if ((grant == GntRead) || !rd_valid) begin
            starve_cnt_d = '0;
        end else if (((grant == GntAlu) || (grant == GntMem)) && (starve_cnt_q != CntMax)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        // Regfile read is combinational; capture it on the grant edge.
        if (grant == GntRead) begin
            rsp_valid_d = 1'b1;
            rsp_a_d     = A_data;
            rsp_b_d     = B_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // MEM as last winner makes the ALU win the first tie.
            rr_last_q    <= SrcMem;
            starve_cnt_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_a_q      <= '0;
            rsp_b_q      <= '0;
        end else begin
            rr_last_q    <= rr_last_d;
            starve_cnt_q <= starve_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_a_q      <= rsp_a_d;
            rsp_b_q      <= rsp_b_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_a_data = rsp_a_q;
    assign rsp_b_data = rsp_b_q;

endmodule
